cpu_bus_responder: RTL

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/bus_pkg.sv | 17 +
 rtl/pia_regs.sv | 62 ++++++
 rtl/cpu_bus_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus responder: PIA register map,
// ROM write-protect base address and memory FSM state encoding.
package bus_pkg;

  localparam logic [15:0] PIA_KBD     = 16'hD010;
  localparam logic [15:0] PIA_KBDCR   = 16'hD011;
  localparam logic [15:0] PIA_DSP     = 16'hD012;
  localparam logic [15:0] PIA_DSPCR   = 16'hD013;
  localparam logic [13:0] PIA_BASE    = PIA_KBD[15:2];
  localparam logic [15:0] ROM_WP_BASE = 16'hFF00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pia_regs.sv
// Keyboard and display registers of the PIA window; read data is combinational
// from current state, updates land on the launch edge; display writes drop while full.
module pia_regs
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] reg_sel,
  input  logic       rd,
  input  logic       wr,
  input  logic [6:0] wdata,
  output logic [7:0] rdata,
  input  logic [6:0] kbd_data,
  input  logic       kbd_valid,
  output logic [6:0] dsp_data,
  output logic       dsp_valid,
  input  logic       dsp_ready
);

  logic [6:0]  kbd_reg;
  logic        kbd_flag;
  logic [15:0] reg_addr;

  assign reg_addr = {PIA_BASE, reg_sel};

  always_comb begin
    rdata = 8'h00;
    case (reg_addr)
      PIA_KBD:   rdata = {1'b1, kbd_reg};
      PIA_KBDCR: rdata = {kbd_flag, 7'b0};
      PIA_DSP:   rdata = {dsp_valid, dsp_data};
      PIA_DSPCR: rdata = 8'h00;
      default:   rdata = 8'h00;
    endcase
  end

  // A new key outranks the read-side clear so a coincident keystroke is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_reg  <= 7'h00;
      kbd_flag <= 1'b0;
    end else if (kbd_valid) begin
      kbd_reg  <= kbd_data;
      kbd_flag <= 1'b1;
    end else if (rd && reg_addr == PIA_KBD) begin
      kbd_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_data  <= 7'h00;
      dsp_valid <= 1'b0;
    end else if (wr && reg_addr == PIA_DSP && !dsp_valid) begin
      dsp_data  <= wdata;
      dsp_valid <= 1'b1;
    end else if (dsp_valid && dsp_ready) begin
      dsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: PIA decode at D010-D013, all else to external memory with MEM_WAIT-clk RDY stall.
// Define ROM_WP_EN to turn memory writes at FF00-FFFF into reads (mem_we held low).
module cpu_bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] ab,
  input  logic [7:0]  dbo,
  input  logic        we,
  output logic [7:0]  dbi,
  output logic        ready,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic [6:0]  kbd_data,
  input  logic        kbd_valid,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        en_q;
  logic        rd_q, rd_d;
  logic        ready_d;
  logic [7:0]  dbi_d;
  logic        cs_d, mem_we_d;
  logic [15:0] addr_d;
  logic [7:0]  wdata_d;
  logic        launch, is_pia, mem_launch, pia_launch, wp_hit;
  logic [7:0]  pia_rdata;

  assign launch     = en_q && (state_q == ST_IDLE);
  assign is_pia     = (ab[15:2] == PIA_BASE);
  assign mem_launch = launch && !is_pia;
  assign pia_launch = launch && is_pia;

`ifdef ROM_WP_EN
  assign wp_hit = (ab >= ROM_WP_BASE);
`else
  assign wp_hit = 1'b0;
`endif

  pia_regs u_pia (
    .clk       (clk),
    .reset     (reset),
    .reg_sel   (ab[1:0]),
    .rd        (pia_launch && !we),
    .wr        (pia_launch && we),
    .wdata     (dbo[6:0]),
    .rdata     (pia_rdata),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid),
    .dsp_ready (dsp_ready)
  );

  // rd_q marks an outstanding read; with MEM_WAIT==0 it completes the clk after mem_cs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    ready_d  = ready;
    dbi_d    = dbi;
    cs_d     = 1'b0;
    mem_we_d = 1'b0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    case (state_q)
      ST_IDLE: begin
        if (rd_q) begin
          dbi_d = mem_rdata;
          rd_d  = 1'b0;
        end
        if (pia_launch && !we) begin
          dbi_d = pia_rdata;
        end
        if (mem_launch) begin
          cs_d     = 1'b1;
          mem_we_d = we && !wp_hit;
          addr_d   = ab;
          wdata_d  = dbo;
          rd_d     = !we;
          if (MEM_WAIT != 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
            ready_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (rd_q) begin
            dbi_d = mem_rdata;
          end
          rd_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rd_q      <= 1'b0;
      dbi       <= 8'h00;
      ready     <= 1'b1;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
    end else begin
      en_q      <= enable;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      dbi       <= dbi_d;
      ready     <= ready_d;
      mem_cs    <= cs_d;
      mem_we    <= mem_we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule
